// File: rtl/sub_add_max_acc.sv
// Two-stage signed sub/add/max/min unit with a result accumulator.
// Define SUB_ADD_MAX_ACC_SAT_EN to saturate overflowing add/sub results.
module sub_add_max_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             ovf
);

  typedef struct packed {
    logic             vld;
    logic             ovf;
    logic [WIDTH-1:0] res;
  } stage_t;

  localparam logic [WIDTH-1:0] MAX_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  stage_t           s1_q, s1_d;
  stage_t           s2_q, s2_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   ext_a, ext_b;
  logic [WIDTH:0]   sum_w, dif_w, arith;
  logic             ar_ovf;
  logic [WIDTH-1:0] ar_res;
  logic             a_ge_b, a_le_b;
  logic             op_sub, op_add, op_max, op_min;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             stall, accept;

  // Operand select and widened arithmetic; the accumulator is
  // updated at acceptance so the next transaction sees it directly.
  always_comb begin
    opa    = use_acc ? acc_q : a;
    ext_a  = {opa[WIDTH-1], opa};
    ext_b  = {b[WIDTH-1], b};
    sum_w  = ext_a + ext_b;
    dif_w  = ext_a - ext_b;
    a_ge_b = $signed(opa) >= $signed(b);
    a_le_b = $signed(opa) <= $signed(b);
    op_sub = (op == 2'b00);
    op_add = (op == 2'b01);
    op_max = (op == 2'b10);
    op_min = (op == 2'b11);
    arith  = op_sub ? dif_w : sum_w;
    ar_ovf = arith[WIDTH] ^ arith[WIDTH-1];
`ifdef SUB_ADD_MAX_ACC_SAT_EN
    if (ar_ovf)
      ar_res = arith[WIDTH] ? MIN_NEG : MAX_POS;
    else
      ar_res = arith[WIDTH-1:0];
`else
    ar_res = arith[WIDTH-1:0];
`endif
  end

  // Result mux; ties in max/min return operand A.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    unique case (1'b1)
      op_sub, op_add: begin
        res     = ar_res;
        res_ovf = ar_ovf;
      end
      op_max: res = a_ge_b ? opa : b;
      op_min: res = a_le_b ? opa : b;
      default: res = '0;
    endcase
  end

  // Handshake: the whole pipe advances unless S2 is blocked.
  always_comb begin
    stall    = s2_q.vld & ~out_ready;
    in_ready = ~stall;
    accept   = in_valid & in_ready;
  end

  // Next-state for both stages and the accumulator.
  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    acc_d = acc_q;
    if (!stall) begin
      s2_d     = s1_q;
      s1_d.vld = accept;
      if (accept) begin
        s1_d.res = res;
        s1_d.ovf = res_ovf;
      end
    end
    if (accept)
      acc_d = res;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      acc_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      acc_q <= acc_d;
    end
  end

  assign out_valid = s2_q.vld;
  assign o         = s2_q.res;
  assign ovf       = s2_q.ovf;

endmodule

// File: tb/tb_sub_add_max_acc.sv
// Directed bench for sub_add_max_acc at WIDTH=16.
// Honors SUB_ADD_MAX_ACC_SAT_EN for saturation expectations.
module tb_sub_add_max_acc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         use_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] o;
  logic         ovf;

  int n_chk = 0;
  int n_pass = 0;

`ifdef SUB_ADD_MAX_ACC_SAT_EN
  localparam logic [W-1:0] ADD_OVF_O = 16'h7FFF;
  localparam logic [W-1:0] SUB_OVF_O = 16'h8000;
`else
  localparam logic [W-1:0] ADD_OVF_O = 16'h8000;
  localparam logic [W-1:0] SUB_OVF_O = 16'h7FFF;
`endif

  always #5 clk = ~clk;

  sub_add_max_acc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .ovf(ovf)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_ovld", out_valid, 0);
    check("rst_o", o, 0);
    check("rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_rdy", in_ready, 1);
  endtask

  task automatic single(input string tag,
                        input logic [1:0] op_i,
                        input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i,
                        input logic ua,
                        input logic [W-1:0] eo,
                        input logic eovf);
    @(negedge clk);
    op = op_i; a = a_i; b = b_i;
    use_acc = ua; out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_o"}, o, eo);
    check({tag, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    logic [W-1:0] held;
    int tx;
    int rx;
    held = '0;
    tx = 0;
    rx = 0;

    #1;
    check("rst0_ovld", out_valid, 0);
    check("rst0_o", o, 0);
    check("rst0_ovf", ovf, 0);
    check("rst0_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel0_rdy", in_ready, 1);

    single("add_ovf", 2'b01, 16'h7FFF, 16'h0001, 0,
           ADD_OVF_O, 1);
    single("max", 2'b10, 16'h8000, 16'h7FFF, 0,
           16'h7FFF, 0);
    single("min", 2'b11, 16'h8000, 16'h7FFF, 0,
           16'h8000, 0);
    single("sub0", 2'b00, 16'h0003, 16'h0003, 0,
           16'h0000, 0);
    single("maxtie", 2'b10, 16'h1234, 16'h1234, 0,
           16'h1234, 0);
    single("sub_ovf", 2'b00, 16'h8000, 16'h0001, 0,
           SUB_OVF_O, 1);
    single("sub_neg", 2'b00, 16'h0002, 16'h0005, 0,
           16'hFFFD, 0);
    single("max_wrap", 2'b10, 16'h7FFF, 16'h8001, 0,
           16'h7FFF, 0);
    single("min_wrap", 2'b11, 16'h7FFF, 16'h8001, 0,
           16'h8001, 0);
    single("acc_use", 2'b01, 16'h1111, 16'h0001, 1,
           16'h8002, 0);

    // back-to-back accumulate from a cleared accumulator
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        check("b2b_vld", out_valid, 1);
        check("b2b_o", o, 64'(5 * (i - 1)));
      end
      if (i < 3) begin
        op = 2'b01; use_acc = 1'b1;
        a = 16'hABCD; b = 16'd5;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // streaming with a 4-cycle downstream stall
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 7);
      if (tx < 8) begin
        op = 2'b01; use_acc = 1'b0;
        a = 16'(tx); b = 16'd100;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 3) held = o;
      if (cyc >= 3 && cyc < 7) begin
        check("stl_vld", out_valid, 1);
        check("stl_rdy", in_ready, 0);
        check("stl_hold", o, held);
      end
      if (out_valid && out_ready) begin
        check("stl_o", o, 64'(rx + 100));
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stl_cnt", 64'(rx), 8);

    // reset with two results in flight
    op = 2'b01; use_acc = 1'b0;
    a = 16'd10; b = 16'd1;
    in_valid = 1'b1;
    @(negedge clk);
    a = 16'd20;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_ovld", out_valid, 0);
    check("mid_o", o, 0);
    check("mid_ovf", ovf, 0);
    check("mid_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rel_rdy", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_stale", out_valid, 0);
    end
    single("mid_acc", 2'b01, 16'hFFFF, 16'h0000, 1,
           16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sub_add_max_acc.md
SUB_ADD_MAX_ACC -- requirements
Module: sub_add_max_acc

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand transaction present.
REQ-005 in_ready  output  1  block accepts the transaction this cycle.
REQ-006 a  input  WIDTH  signed two's-complement operand A.
REQ-007 b  input  WIDTH  signed two's-complement operand B.
REQ-008 op  input  2  operation select: 00 = A-B, 01 = A+B, 10 = max(A,B), 11 = min(A,B).
REQ-009 use_acc  input  1  1 = the accumulator replaces a as operand A.
REQ-010 out_valid  output  1  result present on o/ovf.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 o  output  WIDTH  result.
REQ-013 ovf  output  1  signed overflow flag for the result on o.

Function
REQ-014 A transaction SHALL be accepted exactly when in_valid and in_ready are both 1.
REQ-015 in_ready SHALL equal NOT(out_valid AND NOT out_ready); it SHALL NOT depend combinationally on in_valid.
REQ-016 The pipeline SHALL have two register stages (S1 = compute, S2 = output), with a latency of 2 cycles from acceptance to out_valid when no stall occurs.
REQ-017 Stall: while out_valid=1 and out_ready=0, S1, S2 and the accumulator SHALL hold; o and ovf SHALL stay stable.
REQ-018 A bubble (no acceptance) SHALL propagate as valid=0; sustained throughput SHALL be 1 transaction per cycle.
REQ-019 Operand A SHALL be the accumulator value when use_acc=1, else a.
REQ-020 Add and sub SHALL be computed at WIDTH+1 bits; ovf=1 when the signed result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 Max and min SHALL use a correct signed comparison, valid even when A-B overflows; on a tie the result SHALL be A; ovf=0.
REQ-022 The accumulator SHALL load the transaction's result (after saturation when enabled) on every acceptance, regardless of use_acc.
REQ-023 A transaction accepted with use_acc=1 in the cycle directly after another acceptance SHALL see that previous result (back-to-back forwarding, no bubble).
REQ-024 When out_valid=1 and out_ready=1 in the same cycle as an acceptance, the result SHALL leave S2 and the next result SHALL enter it without loss or duplication.

Reset
REQ-025 On rst_n=0, the block SHALL clear asynchronously: out_valid=0, o=0, ovf=0, S1 valid=0, accumulator=0.
REQ-026 in_ready SHALL read 1 during reset and in the first cycle after release.
REQ-027 Transactions in flight when reset is asserted SHALL be discarded, with no output after release.

Configuration
REQ-028 Macro SUB_ADD_MAX_ACC_SAT_EN. When it is defined, an overflowing add or sub SHALL saturate to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow), with ovf=1.
REQ-029 When SUB_ADD_MAX_ACC_SAT_EN is undefined, the result SHALL wrap modulo 2^WIDTH and ovf SHALL still be reported; max/min SHALL be unaffected in both builds.

Verification (WIDTH=16)
REQ-030 op=01, a=0x7FFF, b=0x0001 -> 2 cycles later out_valid=1, ovf=1, o=0x8000 (SAT off) or o=0x7FFF (SAT on).
REQ-031 op=10, a=0x8000, b=0x7FFF -> o=0x7FFF; op=11 with the same operands -> o=0x8000; ovf=0 in both cases.
REQ-032 Back-to-back op=01 with use_acc=1, b=5, three transactions after reset -> o = 5, 10, 15 on consecutive cycles.
REQ-033 Hold out_ready=0 for 4 cycles with in_valid=1 streaming -> in_ready=0 while stalled, o held, and no transaction lost or duplicated after release.
REQ-034 Assert rst_n=0 mid-stream with two results in flight -> out_valid=0 immediately, accumulator=0, and no stale output after release.
REQ-035 op=00, a=0x0003, b=0x0003 -> o=0x0000, ovf=0; op=10 with a=b=0x1234 -> o=0x1234.
